// File: rtl/ir_beacon_tx_if.sv
// Control/status bundle between the beacon controller and the IR beacon transmitter.
interface ir_beacon_tx_if;
   logic        enable;
   logic        mode;
   logic        freq_sel;
   logic        start;
   logic [15:0] burst_cycles;
   logic [15:0] gap_cycles;
   logic [7:0]  repeat_cnt;
   logic        ir_out;
   logic        busy;
   logic        done;

   modport master (
      output enable, mode, freq_sel, start, burst_cycles, gap_cycles, repeat_cnt,
      input  ir_out, busy, done
   );

   modport slave (
      input  enable, mode, freq_sel, start, burst_cycles, gap_cycles, repeat_cnt,
      output ir_out, busy, done
   );
endinterface

// File: rtl/ir_beacon_tx.sv
// IR beacon transmitter: 1 kHz / 10 kHz square-wave carrier, either continuous
// or as a counted sequence of mark/space bursts with busy/done status.
module ir_beacon_tx #(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned F_LO   = 1_000,
   parameter int unsigned F_HI   = 10_000
) (
   input logic           clk,
   input logic           reset,
   ir_beacon_tx_if.slave bus
);
   localparam logic [23:0] HALF_LO = 24'(CLK_HZ / (2 * F_LO));
   localparam logic [23:0] HALF_HI = 24'(CLK_HZ / (2 * F_HI));

   typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

   state_t      state;
   logic        cont;
   logic        phase;
   logic [23:0] half_lat;
   logic [23:0] half_cnt;
   logic [15:0] burst_lat;
   logic [15:0] gap_lat;
   logic [15:0] period_cnt;
   logic [7:0]  rep_cnt;
   logic        half_end;

   assign half_end = (half_cnt == half_lat - 24'd1);

   // phase: 0 = first half of a carrier period, 1 = second half.
   // period_cnt counts down the periods left in the current MARK or SPACE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cont       <= 1'b0;
         phase      <= 1'b0;
         half_lat   <= '0;
         half_cnt   <= '0;
         burst_lat  <= '0;
         gap_lat    <= '0;
         period_cnt <= '0;
         rep_cnt    <= '0;
         bus.ir_out <= 1'b0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
      end else begin
         // NOTE: done defaults low every cycle so any set below is a one-cycle pulse.
         bus.done <= 1'b0;
         if (!bus.enable) begin
            state      <= IDLE;
            phase      <= 1'b0;
            half_cnt   <= '0;
            bus.ir_out <= 1'b0;
            bus.busy   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (!bus.mode || bus.start) begin
                     if (bus.mode && (bus.burst_cycles == 16'd0 || bus.repeat_cnt == 8'd0)) begin
                        bus.done <= 1'b1;
                     end else begin
                        state      <= MARK;
                        cont       <= !bus.mode;
                        half_lat   <= bus.freq_sel ? HALF_HI : HALF_LO;
                        burst_lat  <= bus.burst_cycles;
                        gap_lat    <= bus.gap_cycles;
                        rep_cnt    <= bus.repeat_cnt;
                        period_cnt <= bus.burst_cycles;
                        phase      <= 1'b0;
                        half_cnt   <= '0;
                        bus.ir_out <= 1'b1;
                        bus.busy   <= 1'b1;
                     end
                  end
               end

               MARK: begin
                  if (cont && bus.mode) begin
                     state      <= IDLE;
                     half_cnt   <= '0;
                     phase      <= 1'b0;
                     bus.ir_out <= 1'b0;
                     bus.busy   <= 1'b0;
                  end else if (!half_end) begin
                     half_cnt <= half_cnt + 24'd1;
                  end else begin
                     half_cnt <= '0;
                     if (!phase) begin
                        phase      <= 1'b1;
                        bus.ir_out <= 1'b0;
                     end else if (cont || period_cnt != 16'd1) begin
                        phase      <= 1'b0;
                        bus.ir_out <= 1'b1;
                        if (!cont) period_cnt <= period_cnt - 16'd1;
                     end else if (gap_lat != 16'd0) begin
                        state      <= SPACE;
                        phase      <= 1'b0;
                        period_cnt <= gap_lat;
                     end else if (rep_cnt == 8'd1) begin
                        state    <= IDLE;
                        phase    <= 1'b0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                     end else begin
                        rep_cnt    <= rep_cnt - 8'd1;
                        period_cnt <= burst_lat;
                        phase      <= 1'b0;
                        bus.ir_out <= 1'b1;
                     end
                  end
               end

               SPACE: begin
                  if (!half_end) begin
                     half_cnt <= half_cnt + 24'd1;
                  end else begin
                     half_cnt <= '0;
                     if (!phase) begin
                        phase <= 1'b1;
                     end else if (period_cnt != 16'd1) begin
                        phase      <= 1'b0;
                        period_cnt <= period_cnt - 16'd1;
                     end else if (rep_cnt == 8'd1) begin
                        state    <= IDLE;
                        phase    <= 1'b0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                     end else begin
                        state      <= MARK;
                        rep_cnt    <= rep_cnt - 8'd1;
                        period_cnt <= burst_lat;
                        phase      <= 1'b0;
                        bus.ir_out <= 1'b1;
                     end
                  end
               end

               default: begin
                  state      <= IDLE;
                  bus.ir_out <= 1'b0;
                  bus.busy   <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule
